// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: definitions shared by the program loader and the CPU
// control decoder.
//   state_t      - loader FSM states
//   HALT_OPCODE  - opcode value that ends a program load
//   OPCODE_MSB/LSB, OPCODE_W - position of the opcode field in a 16-bit word
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LO,
    WAIT_HI,
    WRITE,
    DONE
  } state_t;

  localparam int OPCODE_W   = 5;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'b00000;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: fills program memory from a UART byte stream and holds the CPU
// in reset until a HALT word has been stored or memory is full.
// Bytes arrive low byte first; each pair becomes one instruction written to
// consecutive addresses starting at 0. NBITS_D must equal 2*NBITS_B.
//
// Ports:
//   i_clock     - system clock
//   i_reset     - synchronous reset, active-high
//   i_start     - one-cycle pulse that arms a new load (from IDLE or DONE)
//   i_rx_done   - one-cycle strobe, i_rx_data is valid
//   i_rx_data   - received byte
//   o_pm_we     - program-memory write enable, one cycle per word
//   o_pm_addr   - program-memory write address
//   o_pm_data   - instruction to write
//   o_cpu_reset - CPU reset, low only in DONE
//   o_busy      - load in progress
//   o_done      - load finished
//   o_overflow  - sticky, memory filled without a HALT
//   o_count     - words written in the current load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int NBITS_B = 8,
  parameter int OPCODE  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_rx_done,
  input  logic [NBITS_B-1:0] i_rx_data,
  output logic               o_pm_we,
  output logic [NBITS_O-1:0] o_pm_addr,
  output logic [NBITS_D-1:0] o_pm_data,
  output logic               o_cpu_reset,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [NBITS_O:0]   o_count
);

  localparam logic [OPCODE-1:0]  HALT_CODE = OPCODE'(HALT_OPCODE);
  localparam logic [NBITS_O-1:0] LAST_ADDR = {NBITS_O{1'b1}};

  state_t               state;
  logic                 pm_we;
  logic [NBITS_O-1:0]   pm_addr;
  logic [NBITS_D-1:0]   pm_data;
  logic                 cpu_reset;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [NBITS_O:0]     count;
  logic                 pending;
  logic [NBITS_B-1:0]   pending_byte;

  logic is_halt;
  logic at_last;

  assign is_halt = (pm_data[NBITS_D-1 -: OPCODE] == HALT_CODE);
  assign at_last = (pm_addr == LAST_ADDR);

  // pm_data doubles as the byte-assembly register: the low half is filled in
  // WAIT_LO and the high half in WAIT_HI, so the word is complete and stable
  // for the whole WRITE cycle. A byte that arrives while WRITE is busy is
  // parked in pending_byte and becomes the next low byte. A pending byte left
  // over when the load ends is discarded by the next start.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      pm_we        <= 1'b0;
      pm_addr      <= '0;
      pm_data      <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      count        <= '0;
      pending      <= 1'b0;
      pending_byte <= '0;
    end else begin
      pm_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state     <= WAIT_LO;
            pm_addr   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cpu_reset <= 1'b1;
            pending   <= 1'b0;
          end
        end
        WAIT_LO: begin
          if (pending) begin
            pm_data[NBITS_B-1:0] <= pending_byte;
            pending              <= 1'b0;
            state                <= WAIT_HI;
          end else if (i_rx_done) begin
            pm_data[NBITS_B-1:0] <= i_rx_data;
            state                <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (i_rx_done) begin
            pm_data[NBITS_D-1:NBITS_B] <= i_rx_data;
            pm_we                      <= 1'b1;
            state                      <= WRITE;
          end
        end
        WRITE: begin
          count <= count + 1'b1;
          if (i_rx_done) begin
            pending      <= 1'b1;
            pending_byte <= i_rx_data;
          end
          // HALT takes priority so a HALT at the last address is not
          // reported as an overflow.
          if (is_halt || at_last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
            overflow  <= !is_halt;
          end else begin
            pm_addr <= pm_addr + 1'b1;
            state   <= WAIT_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_pm_we     = pm_we;
  assign o_pm_addr   = pm_addr;
  assign o_pm_data   = pm_data;
  assign o_cpu_reset = cpu_reset;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_overflow  = overflow;
  assign o_count     = count;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. dut0 uses the default
// 11-bit address space, dut1 a 3-bit one so the memory-full path is reachable.
// Every completed load is compared against a word-level model of the load.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, rxd0, start1, rxd1;
  logic [7:0]  rxdata0, rxdata1;

  logic        we0, cpures0, busy0, done0, ovf0;
  logic [10:0] addr0;
  logic [15:0] data0;
  logic [11:0] cnt0;
  logic        we1, cpures1, busy1, done1, ovf1;
  logic [2:0]  addr1;
  logic [15:0] data1;
  logic [3:0]  cnt1;

  prog_loader dut0 (
    .i_clock(clk), .i_reset(reset), .i_start(start0), .i_rx_done(rxd0),
    .i_rx_data(rxdata0), .o_pm_we(we0), .o_pm_addr(addr0), .o_pm_data(data0),
    .o_cpu_reset(cpures0), .o_busy(busy0), .o_done(done0), .o_overflow(ovf0),
    .o_count(cnt0)
  );

  prog_loader #(.NBITS_O(3)) dut1 (
    .i_clock(clk), .i_reset(reset), .i_start(start1), .i_rx_done(rxd1),
    .i_rx_data(rxdata1), .o_pm_we(we1), .o_pm_addr(addr1), .o_pm_data(data1),
    .o_cpu_reset(cpures1), .o_busy(busy1), .o_done(done1), .o_overflow(ovf1),
    .o_count(cnt1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Write log and memory image captured from each DUT.
  int          act_addr0[$], act_addr1[$];
  logic [15:0] act_data0[$], act_data1[$];
  logic [15:0] mem0 [0:2047];

  // Model inputs/outputs.
  logic [15:0] words_q[$];
  int          exp_addr[$];
  logic [15:0] exp_data[$];
  bit          exp_ovf;

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      act_addr0.push_back(int'(addr0));
      act_data0.push_back(data0);
      mem0[addr0] = data0;
    end
    if (we1 === 1'b1) begin
      act_addr1.push_back(int'(addr1));
      act_data1.push_back(data1);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int tgt, input logic st, input logic rd, input logic [7:0] d);
    if (tgt == 0) begin start0 = st; rxd0 = rd; rxdata0 = d; end
    else          begin start1 = st; rxd1 = rd; rxdata1 = d; end
  endtask

  task automatic send_byte(input int tgt, input logic [7:0] b, input int gap);
    drive(tgt, 1'b0, 1'b1, b);
    tick();
    drive(tgt, 1'b0, 1'b0, b);
    repeat (gap) tick();
  endtask

  task automatic pulse_start(input int tgt);
    drive(tgt, 1'b1, 1'b0, 8'h00);
    tick();
    drive(tgt, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_logs();
    act_addr0.delete(); act_data0.delete();
    act_addr1.delete(); act_data1.delete();
  endtask

  task automatic wait_done(input int tgt, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if ((tgt == 0 && done0 === 1'b1) || (tgt == 1 && done1 === 1'b1)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Load model: words go to 0,1,2,...; the load stops after the first word
  // with a zero opcode, or after the last address with the overflow flag.
  task automatic model_run(input int aw);
    int a;
    exp_addr.delete(); exp_data.delete();
    exp_ovf = 1'b0;
    a = 0;
    foreach (words_q[i]) begin
      exp_addr.push_back(a);
      exp_data.push_back(words_q[i]);
      if (words_q[i][15:11] == 5'd0) break;
      if (a == (1 << aw) - 1) begin exp_ovf = 1'b1; break; end
      a++;
    end
  endtask

  // Sends words_q low byte first with random gaps. A high byte followed with
  // no gap lands the next low byte in the WRITE cycle; that byte must then be
  // followed by at least one idle cycle.
  task automatic send_words(input int tgt);
    bit force_gap;
    int g;
    force_gap = 1'b0;
    foreach (words_q[i]) begin
      for (int half = 0; half < 2; half++) begin
        g = $urandom_range(0, 2);
        if (force_gap && g == 0) g = 1;
        force_gap = (half == 1 && g == 0);
        send_byte(tgt, half ? words_q[i][15:8] : words_q[i][7:0], g);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    vectors++; if (we0 !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_we got %b exp 0", we0); end
    vectors++; if (addr0 !== 11'd0)   begin miscompares++; $display("[TB] FAIL reset_addr got %0d exp 0", addr0); end
    vectors++; if (data0 !== 16'h0)   begin miscompares++; $display("[TB] FAIL reset_data got %h exp 0000", data0); end
    vectors++; if (cpures0 !== 1'b1)  begin miscompares++; $display("[TB] FAIL reset_cpu_reset got %b exp 1", cpures0); end
    vectors++; if (busy0 !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", busy0); end
    vectors++; if (done0 !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_done got %b exp 0", done0); end
    vectors++; if (ovf0 !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_overflow got %b exp 0", ovf0); end
    vectors++; if (cnt0 !== 12'd0)    begin miscompares++; $display("[TB] FAIL reset_count got %0d exp 0", cnt0); end
    vectors++; if (cpures1 !== 1'b1 || cnt1 !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_small got cpu_reset=%b count=%0d exp 1/0", cpures1, cnt1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    bit ok;
    clear_logs();
    pulse_start(0);
    vectors++; if (busy0 !== 1'b1 || cpures0 !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_armed got busy=%b cpu_reset=%b exp 1/1", busy0, cpures0); end
    send_byte(0, 8'h05, 1);
    send_byte(0, 8'h08, 1);
    send_byte(0, 8'h00, 1);
    send_byte(0, 8'h00, 0);
    vectors++; if (we0 !== 1'b1 || cpures0 !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_last_write got we=%b cpu_reset=%b exp 1/1", we0, cpures0); end
    tick();
    vectors++; if (cpures0 !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_cpu_release got %b exp 0", cpures0); end
    wait_done(0, 10, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL basic_done got timeout exp done"); end
    vectors++; if (cnt0 !== 12'd2 || ovf0 !== 1'b0 || addr0 !== 11'd1) begin miscompares++; $display("[TB] FAIL basic_status got count=%0d ovf=%b addr=%0d exp 2/0/1", cnt0, ovf0, addr0); end
    vectors++;
    if (act_addr0.size() != 2 || act_addr0[0] != 0 || act_data0[0] !== 16'h0805 || act_addr0[1] != 1 || act_data0[1] !== 16'h0000) begin
      miscompares++; $display("[TB] FAIL basic_writes got %0d writes exp 0:0805 1:0000", act_addr0.size());
    end
  endtask

  task automatic test_write_latency();
    bit ok;
    pulse_start(0);
    send_byte(0, 8'h34, 1);
    drive(0, 1'b0, 1'b1, 8'h12);
    vectors++; if (we0 !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early got we=%b exp 0", we0); end
    tick();
    drive(0, 1'b0, 1'b0, 8'h00);
    vectors++; if (we0 !== 1'b1 || data0 !== 16'h1234 || addr0 !== 11'd0) begin miscompares++; $display("[TB] FAIL latency_write got we=%b data=%h addr=%0d exp 1/1234/0", we0, data0, addr0); end
    tick();
    vectors++; if (we0 !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_single got we=%b exp 0", we0); end
    send_byte(0, 8'h00, 1);
    send_byte(0, 8'h00, 1);
    wait_done(0, 10, ok);
    vectors++; if (!ok || cnt0 !== 12'd2) begin miscompares++; $display("[TB] FAIL latency_done got done=%b count=%0d exp 1/2", ok, cnt0); end
  endtask

  task automatic test_pending();
    bit ok;
    clear_logs();
    pulse_start(0);
    send_byte(0, 8'h05, 1);
    send_byte(0, 8'h08, 0);
    send_byte(0, 8'hAA, 2);
    send_byte(0, 8'h00, 1);
    wait_done(0, 10, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL pending_done got timeout exp done"); end
    vectors++;
    if (act_addr0.size() != 2 || act_data0[0] !== 16'h0805 || act_addr0[1] != 1 || act_data0[1] !== 16'h00AA) begin
      miscompares++; $display("[TB] FAIL pending_writes got %0d writes exp 0:0805 1:00AA", act_addr0.size());
    end
  endtask

  task automatic test_start_edges();
    bit ok;
    clear_logs();
    drive(0, 1'b1, 1'b1, 8'h77);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00);
    send_byte(0, 8'h22, 1);
    pulse_start(0);
    send_byte(0, 8'h00, 1);
    wait_done(0, 10, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL start_edge_done got timeout exp done"); end
    vectors++;
    if (act_addr0.size() != 1 || act_data0[0] !== 16'h0022 || cnt0 !== 12'd1) begin
      miscompares++; $display("[TB] FAIL start_edge_writes got %0d writes count=%0d exp one 0:0022", act_addr0.size(), cnt0);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    bit good;
    clear_logs();
    pulse_start(1);
    for (int i = 0; i < 8; i++) begin
      send_byte(1, 8'h01, 1);
      send_byte(1, 8'h08, 1);
    end
    wait_done(1, 10, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL overflow_done got timeout exp done"); end
    vectors++; if (ovf1 !== 1'b1 || cnt1 !== 4'd8 || addr1 !== 3'd7) begin miscompares++; $display("[TB] FAIL overflow_status got ovf=%b count=%0d addr=%0d exp 1/8/7", ovf1, cnt1, addr1); end
    send_byte(1, 8'h01, 1);
    send_byte(1, 8'h08, 2);
    good = (act_addr1.size() == 8);
    for (int i = 0; i < act_addr1.size() && i < 8; i++)
      if (act_addr1[i] != i || act_data1[i] !== 16'h0801) good = 1'b0;
    vectors++; if (!good) begin miscompares++; $display("[TB] FAIL overflow_writes got %0d writes exp addr 0..7 of 0801", act_addr1.size()); end
  endtask

  task automatic test_reset_mid_load();
    clear_logs();
    pulse_start(0);
    for (int i = 0; i < 3; i++) begin
      send_byte(0, 8'(8'h10 + i), 1);
      send_byte(0, 8'h08, 1);
    end
    send_byte(0, 8'h44, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (busy0 !== 1'b0 || cpures0 !== 1'b1 || cnt0 !== 12'd0 || done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_state got busy=%b cpu_reset=%b count=%0d done=%b exp 0/1/0/0", busy0, cpures0, cnt0, done0); end
    vectors++; if (mem0[2] !== 16'h0812) begin miscompares++; $display("[TB] FAIL midreset_kept got %h exp 0812", mem0[2]); end
    for (int i = 0; i < 4; i++) send_byte(0, 8'(i + 1), 1);
    tick();
    vectors++; if (act_addr0.size() != 3) begin miscompares++; $display("[TB] FAIL midreset_idle_writes got %0d writes exp 3", act_addr0.size()); end
  endtask

  task automatic test_restart();
    bit ok;
    pulse_start(0);
    send_byte(0, 8'h34, 1);
    send_byte(0, 8'h12, 1);
    send_byte(0, 8'h00, 1);
    send_byte(0, 8'h00, 1);
    wait_done(0, 10, ok);
    vectors++; if (!ok || cnt0 !== 12'd2 || mem0[0] !== 16'h1234) begin miscompares++; $display("[TB] FAIL restart_first got done=%b count=%0d mem0=%h exp 1/2/1234", ok, cnt0, mem0[0]); end
    clear_logs();
    pulse_start(0);
    vectors++; if (cpures0 !== 1'b1 || done0 !== 1'b0 || cnt0 !== 12'd0 || busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_armed got cpu_reset=%b done=%b count=%0d busy=%b exp 1/0/0/1", cpures0, done0, cnt0, busy0); end
    send_byte(0, 8'h00, 1);
    send_byte(0, 8'h00, 1);
    wait_done(0, 10, ok);
    vectors++; if (!ok || cnt0 !== 12'd1 || mem0[0] !== 16'h0000 || act_addr0.size() != 1) begin miscompares++; $display("[TB] FAIL restart_second got done=%b count=%0d mem0=%h writes=%0d exp 1/1/0000/1", ok, cnt0, mem0[0], act_addr0.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int tgt, aw, n, act_cnt, act_last;
    bit act_ovf, act_cpu;
    int aa[$];
    logic [15:0] ad[$];
    logic [15:0] w;
    for (int load = 0; load < 16; load++) begin
      tgt = (load % 4 == 3) ? 1 : 0;
      aw  = (tgt == 0) ? 11 : 3;
      words_q.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 9) == 0) w[15:11] = 5'd0;
        words_q.push_back(w);
      end
      words_q.push_back({5'd0, 11'($urandom)});
      model_run(aw);
      clear_logs();
      pulse_start(tgt);
      send_words(tgt);
      wait_done(tgt, 20, ok);
      tick();
      act_cnt  = (tgt == 0) ? int'(cnt0) : int'(cnt1);
      act_ovf  = (tgt == 0) ? ovf0 : ovf1;
      act_cpu  = (tgt == 0) ? cpures0 : cpures1;
      act_last = (tgt == 0) ? int'(addr0) : int'(addr1);
      if (tgt == 0) begin aa = act_addr0; ad = act_data0; end
      else          begin aa = act_addr1; ad = act_data1; end
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL rand%0d_done got timeout exp done", load); end
      vectors++; if (act_cnt != exp_addr.size() || act_ovf != exp_ovf) begin miscompares++; $display("[TB] FAIL rand%0d_status got count=%0d ovf=%b exp %0d/%b", load, act_cnt, act_ovf, exp_addr.size(), exp_ovf); end
      vectors++; if (act_cpu !== 1'b0 || act_last != exp_addr[exp_addr.size()-1]) begin miscompares++; $display("[TB] FAIL rand%0d_final got cpu_reset=%b addr=%0d exp 0/%0d", load, act_cpu, act_last, exp_addr[exp_addr.size()-1]); end
      vectors++; if (aa.size() != exp_addr.size()) begin miscompares++; $display("[TB] FAIL rand%0d_nwrites got %0d exp %0d", load, aa.size(), exp_addr.size()); end
      for (int i = 0; i < aa.size() && i < exp_addr.size(); i++) begin
        vectors++;
        if (aa[i] != exp_addr[i] || ad[i] !== exp_data[i]) begin
          miscompares++; $display("[TB] FAIL rand%0d_write%0d got %0d:%h exp %0d:%h", load, i, aa[i], ad[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] prog_loader bench start");
    test_reset();
    test_basic_load();
    test_write_latency();
    test_pending();
    test_start_edges();
    test_overflow();
    test_reset_mid_load();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
